mem_bus_master: RTL and testbench

Data-memory access engine for the MEM stage. It consumes the load/store fields held in the EX/MEM pipeline register and runs single-outstanding transactions on the data bus using a req/ack handshake. While a transaction is in flight it requests a pipeline stall, then presents load data, after sign or zero extension, to MEM/WB. It also detects misaligned accesses and bus timeouts.

---
 rtl/mem_bus_master_if.sv | 30 +++
 rtl/mem_bus_master.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_bus_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - req/ack data bus between the MEM-stage master and the memory slave
interface mem_bus_master_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_sel,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_sel,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - MEM-stage load/store engine: single-outstanding req/ack bus master with stall,
// load extension, misalignment and bus-timeout detection.
module mem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             mem_aluop,
  input  logic [31:0]            mem_mem_addr,
  input  logic [31:0]            mem_reg2,
  input  logic [4:0]             mem_wd,
  input  logic                   mem_wreg,
  input  logic [31:0]            mem_wdata,
  input  logic                   flush,
  mem_bus_master_if.master       bus,
  output logic                   stallreq_mem,
  output logic [4:0]             wb_wd,
  output logic                   wb_wreg,
  output logic [31:0]            wb_wdata,
  output logic                   exc_adel,
  output logic                   exc_ades,
  output logic                   exc_buserr
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        is_load_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [1:0]  acc_size;
  logic        ld_unsigned;
  logic        misaligned;
  logic        start;
  logic [3:0]  lane_sel;
  logic [31:0] store_data;
  logic [31:0] load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    acc_size    = SZ_WORD;
    ld_unsigned = 1'b0;
    case (mem_aluop)
      OP_LB:  begin is_load  = 1'b1; acc_size = SZ_BYTE; end
      OP_LBU: begin is_load  = 1'b1; acc_size = SZ_BYTE; ld_unsigned = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; acc_size = SZ_HALF; end
      OP_LHU: begin is_load  = 1'b1; acc_size = SZ_HALF; ld_unsigned = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; acc_size = SZ_WORD; end
      OP_SB:  begin is_store = 1'b1; acc_size = SZ_BYTE; end
      OP_SH:  begin is_store = 1'b1; acc_size = SZ_HALF; end
      OP_SW:  begin is_store = 1'b1; acc_size = SZ_WORD; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = ((acc_size == SZ_HALF) && mem_mem_addr[0]) ||
                      ((acc_size == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00));
  assign start      = (state == ST_IDLE) && is_mem && !misaligned && !flush;

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    lane_sel   = 4'b1111;
    store_data = mem_reg2;
    case (acc_size)
      SZ_BYTE: begin
        store_data = {4{mem_reg2[7:0]}};
        case (mem_mem_addr[1:0])
          2'd0:    lane_sel = 4'b1000;
          2'd1:    lane_sel = 4'b0100;
          2'd2:    lane_sel = 4'b0010;
          default: lane_sel = 4'b0001;
        endcase
      end
      SZ_HALF: begin
        store_data = {2{mem_reg2[15:0]}};
        lane_sel   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.bus_rdata[31:24];
      2'd1:    ld_byte = bus.bus_rdata[23:16];
      2'd2:    ld_byte = bus.bus_rdata[15:8];
      default: ld_byte = bus.bus_rdata[7:0];
    endcase
    ld_half = off_q[1] ? bus.bus_rdata[15:0] : bus.bus_rdata[31:16];
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_ext = unsigned_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= 8'd0;
      err_q         <= 1'b0;
      rdata_q       <= 32'd0;
      is_load_q     <= 1'b0;
      size_q        <= SZ_WORD;
      unsigned_q    <= 1'b0;
      off_q         <= 2'd0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_sel   <= 4'd0;
      bus.bus_wdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= is_store;
            bus.bus_addr  <= {mem_mem_addr[31:2], 2'b00};
            bus.bus_sel   <= lane_sel;
            bus.bus_wdata <= store_data;
            is_load_q     <= is_load;
            size_q        <= acc_size;
            unsigned_q    <= ld_unsigned;
            off_q         <= mem_mem_addr[1:0];
            wait_cnt      <= 8'd0;
            err_q         <= 1'b0;
            state         <= ST_BUS;
          end
        end
        ST_BUS: begin
          wait_cnt <= wait_cnt + 8'd1;
          // An ack on the terminal-count cycle still counts as success.
          if (bus.bus_ack) begin
            if (is_load_q) begin
              rdata_q <= load_ext;
            end
            bus.bus_req <= 1'b0;
            state       <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.bus_req <= 1'b0;
            err_q       <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          bus.bus_req <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    stallreq_mem = 1'b0;
    exc_adel     = 1'b0;
    exc_ades     = 1'b0;
    exc_buserr   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A memory op never writes back from IDLE; its result appears in DONE.
        if (is_mem) begin
          wb_wreg = 1'b0;
          if (misaligned) begin
            exc_adel = is_load;
            exc_ades = is_store;
          end else if (!flush) begin
            stallreq_mem = 1'b1;
          end
        end
      end
      ST_BUS: begin
        stallreq_mem = 1'b1;
        wb_wreg      = 1'b0;
      end
      ST_DONE: begin
        exc_buserr = err_q;
        if (is_load_q) begin
          wb_wdata = rdata_q;
          wb_wreg  = mem_wreg & ~err_q;
        end else begin
          wb_wreg = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - directed and randomized checks of mem_bus_master against a behavioural model.
module tb_mem_bus_master;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        stallreq_mem;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_buserr;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_master_if bus_if ();

  mem_bus_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .flush        (flush),
    .bus          (bus_if.master),
    .stallreq_mem (stallreq_mem),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades),
    .exc_buserr   (exc_buserr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [7:0] op);
    if (op inside {8'hE0, 8'hE4, 8'hE8}) return 1;
    if (op inside {8'hE1, 8'hE5, 8'hE9}) return 2;
    if (op inside {8'hE3, 8'hEB}) return 4;
    return 0;
  endfunction

  function automatic bit op_is_store(input logic [7:0] op);
    return op inside {8'hE8, 8'hE9, 8'hEB};
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] a);
    case (op_size(op))
      1:       return 4'b1000 >> a[1:0];
      2:       return 4'b1100 >> a[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] d);
    case (op_size(op))
      1:       return {4{d[7:0]}};
      2:       return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    case (op_size(op))
      1: begin
        sh = 8 * (3 - int'(a[1:0]));
        v  = (rd >> sh) & 32'h0000_00FF;
        if (op == 8'hE0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      2: begin
        sh = 8 * (2 - int'(a[1:0]));
        v  = (rd >> sh) & 32'h0000_FFFF;
        if (op == 8'hE1 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // ack_at: BUS-cycle index carrying bus_ack; values >= T mean the slave never answers.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input int ack_at, input logic [31:0] rdata);
    logic [4:0] wd;
    int stall_n;
    int req_n;
    bit stable_ok;
    bit done;
    bit ld;
    bit err;
    ld  = !op_is_store(op);
    err = (ack_at >= T);
    wd  = 5'($urandom);
    @(negedge clk);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wd       = wd;
    mem_wreg     = 1'b1;
    mem_wdata    = $urandom;
    flush        = 1'b0;
    #1;
    stall_n = 0; req_n = 0; stable_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!stallreq_mem) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (bus_if.bus_req) begin
          if (bus_if.bus_addr !== {addr[31:2], 2'b00} || bus_if.bus_sel !== exp_sel(op, addr) ||
              bus_if.bus_we !== op_is_store(op) ||
              (op_is_store(op) && bus_if.bus_wdata !== exp_wdata(op, reg2)))
            stable_ok = 1'b0;
          if (req_n == ack_at) begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = rdata;
          end
          req_n++;
          flush = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
        #1;
      end
    end
    flush = 1'b0;
    check("done_reached", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_n), err ? 32'(T + 1) : 32'(ack_at + 2));
    check("req_cycles", 32'(req_n), err ? 32'(T) : 32'(ack_at + 1));
    check("bus_fields", 32'(stable_ok), 32'd1);
    check("done_req_low", 32'(bus_if.bus_req), 32'd0);
    check("exc_buserr", 32'(exc_buserr), 32'(err));
    check("wb_wreg", 32'(wb_wreg), 32'(ld && !err));
    check("wb_wd", 32'(wb_wd), 32'(wd));
    if (ld && !err) check("wb_wdata", wb_wdata, exp_load(op, addr, rdata));
  endtask

  task automatic run_misaligned(input logic [7:0] op, input logic [31:0] addr);
    bit req_seen;
    @(negedge clk);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = $urandom;
    mem_wreg     = 1'b1;
    flush        = 1'b0;
    #1;
    check("adel", 32'(exc_adel), 32'(!op_is_store(op)));
    check("ades", 32'(exc_ades), 32'(op_is_store(op)));
    check("mis_stall", 32'(stallreq_mem), 32'd0);
    check("mis_wreg", 32'(wb_wreg), 32'd0);
    req_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (bus_if.bus_req) req_seen = 1'b1;
    end
    check("mis_no_req", 32'(req_seen), 32'd0);
  endtask

  task automatic run_passthrough();
    logic [7:0] op;
    do op = 8'($urandom); while (op_size(op) != 0);
    @(negedge clk);
    mem_aluop = op;
    mem_wd    = 5'($urandom);
    mem_wreg  = 1'($urandom);
    mem_wdata = $urandom;
    flush     = 1'b0;
    #1;
    check("pt_wd", 32'(wb_wd), 32'(mem_wd));
    check("pt_wreg", 32'(wb_wreg), 32'(mem_wreg));
    check("pt_wdata", wb_wdata, mem_wdata);
    check("pt_stall", 32'(stallreq_mem), 32'd0);
  endtask

  logic [7:0] ops [8] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] addr;
    int          sz;
    bit          seen;

    rst = 1'b0;
    mem_aluop = 8'h00; mem_mem_addr = '0; mem_reg2 = '0;
    mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; flush = 1'b0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_we", 32'(bus_if.bus_we), 32'd0);
    check("rst_addr", bus_if.bus_addr, 32'd0);
    check("rst_sel", 32'(bus_if.bus_sel), 32'd0);
    check("rst_wdata", bus_if.bus_wdata, 32'd0);
    check("rst_stall", 32'(stallreq_mem), 32'd0);
    check("rst_buserr", 32'(exc_buserr), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_passthrough();
    run_mem(8'hE3, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
    check("lw_done_sel", 32'(bus_if.bus_sel), 32'hF);
    check("lw_done_data", wb_wdata, 32'hDEAD_BEEF);
    run_mem(8'hE0, 32'h0000_0103, 32'h0, 0, 32'h0000_00F0);
    check("lb_data", wb_wdata, 32'hFFFF_FFF0);
    run_mem(8'hE4, 32'h0000_0103, 32'h0, 1, 32'h0000_00F0);
    check("lbu_data", wb_wdata, 32'h0000_00F0);
    run_mem(8'hE9, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0);
    check("sh_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
    check("sh_sel", 32'(bus_if.bus_sel), 32'h3);
    run_misaligned(8'hE3, 32'h0000_0101);
    run_misaligned(8'hE9, 32'h0000_0201);
    run_misaligned(8'hE1, 32'h0000_0103);
    run_misaligned(8'hEB, 32'h0000_0202);
    run_mem(8'hE3, 32'h0000_0400, 32'h0, T, 32'h1111_2222);
    run_mem(8'hE5, 32'h0000_0402, 32'h0, T - 1, 32'h8765_F00D);
    run_mem(8'hEB, 32'h0000_0404, 32'h5555_AAAA, T, 32'h0);

    // Flushed aligned op in IDLE starts no bus cycle.
    @(negedge clk);
    mem_aluop = 8'hE3; mem_mem_addr = 32'h0000_0500; flush = 1'b1;
    #1;
    check("flush_stall", 32'(stallreq_mem), 32'd0);
    @(negedge clk); #1;
    check("flush_no_req", 32'(bus_if.bus_req), 32'd0);
    flush = 1'b0;
    mem_aluop = 8'h00;

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    mem_aluop = 8'hE3; mem_mem_addr = 32'h0000_0300; mem_wreg = 1'b1;
    @(negedge clk); #1;
    check("mid_req_up", 32'(bus_if.bus_req), 32'd1);
    #2;
    rst = 1'b0;
    mem_aluop = 8'h00;
    mem_wdata = 32'hCAFE_0001;
    #1;
    check("mid_rst_req", 32'(bus_if.bus_req), 32'd0);
    check("mid_rst_stall", 32'(stallreq_mem), 32'd0);
    check("mid_rst_idle", wb_wdata, 32'hCAFE_0001);
    @(negedge clk);
    rst = 1'b1;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    check("stray_ack_req", 32'(bus_if.bus_req), 32'd0);
    check("stray_ack_stall", 32'(stallreq_mem), 32'd0);
    check("stray_ack_wdata", wb_wdata, 32'hCAFE_0001);
    run_mem(8'hE3, 32'h0000_0300, 32'h0, 1, 32'h1357_9BDF);

    for (int i = 0; i < 40; i++) begin
      op   = ops[$urandom_range(0, 7)];
      sz   = op_size(op);
      addr = $urandom & ~32'(sz - 1);
      if (i % 7 == 3) run_passthrough();
      run_mem(op, addr, $urandom, $urandom_range(0, T), $urandom);
    end

    @(negedge clk);
    mem_aluop = 8'h00;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus_if.bus_req || stallreq_mem) seen = 1'b1;
    end
    check("final_quiet", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
